// File: rtl/fir_cfg_pkg.sv
// FIR configuration master shared definitions.
// Command op encodings, FSM states, FIR register map.
package fir_cfg_pkg;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_POLL  = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    localparam logic [11:0] REG_AP_CTRL     = 12'h000;
    localparam logic [11:0] REG_DATA_LENGTH = 12'h010;
    localparam logic [11:0] REG_TAP_BASE    = 12'h020;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_A,
        RD_D,
        POLL_GAP,
        RSP
    } state_t;

endpackage

// File: rtl/fir_cfg_master.sv
// Command-driven AXI-Lite master: write, read, poll-until-mask.
// Ports: cmd_* in, rsp_* out, AW/W/AR/R AXI-Lite (no B channel).
module fir_cfg_master
    import fir_cfg_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int pPOLL_MAX   = 1024
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [pADDR_WIDTH-1:0] cmd_addr,
    input  logic [pDATA_WIDTH-1:0] cmd_wdata,
    input  logic [pDATA_WIDTH-1:0] cmd_mask,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [pDATA_WIDTH-1:0] rsp_data,
    output logic                   rsp_timeout,
    output logic                   awvalid,
    input  logic                   awready,
    output logic [pADDR_WIDTH-1:0] awaddr,
    output logic                   wvalid,
    input  logic                   wready,
    output logic [pDATA_WIDTH-1:0] wdata,
    output logic                   arvalid,
    input  logic                   arready,
    output logic [pADDR_WIDTH-1:0] araddr,
    input  logic                   rvalid,
    output logic                   rready,
    input  logic [pDATA_WIDTH-1:0] rdata
);

    localparam int CW = $clog2(pPOLL_MAX) + 1;

    state_t                 state;
    logic [1:0]             op_q;
    logic [pDATA_WIDTH-1:0] mask_q;
    logic [CW-1:0]          poll_cnt;
    logic                   aw_done;
    logic                   w_done;

    logic                   aw_hs;
    logic                   w_hs;
    logic [CW-1:0]          poll_nxt;

    always_comb begin
        aw_hs    = awvalid && awready;
        w_hs     = wvalid && wready;
        poll_nxt = poll_cnt + 1'b1;
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state       <= IDLE;
            op_q        <= OP_WRITE;
            mask_q      <= '0;
            poll_cnt    <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_timeout <= 1'b0;
            awvalid     <= 1'b0;
            awaddr      <= '0;
            wvalid      <= 1'b0;
            wdata       <= '0;
            arvalid     <= 1'b0;
            araddr      <= '0;
            rready      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        op_q      <= cmd_op;
                        mask_q    <= cmd_mask;
                        awaddr    <= cmd_addr;
                        araddr    <= cmd_addr;
                        wdata     <= cmd_wdata;
                        poll_cnt  <= '0;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                        if (cmd_op == OP_WRITE) begin
                            state   <= WR;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                        end else begin
                            state   <= RD_A;
                            arvalid <= 1'b1;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                WR: begin
                    if (aw_hs) begin
                        awvalid <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid <= 1'b0;
                        w_done <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        state       <= RSP;
                        rsp_valid   <= 1'b1;
                        rsp_data    <= '0;
                        rsp_timeout <= 1'b0;
                    end
                end
                RD_A: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RD_D;
                    end
                end
                RD_D: begin
                    if (rvalid) begin
                        rready   <= 1'b0;
                        rsp_data <= rdata;
                        if (op_q != OP_POLL) begin
                            state       <= RSP;
                            rsp_valid   <= 1'b1;
                            rsp_timeout <= 1'b0;
                        end else if (|(rdata & mask_q)) begin
                            state       <= RSP;
                            rsp_valid   <= 1'b1;
                            rsp_timeout <= 1'b0;
                        end else begin
                            poll_cnt <= poll_nxt;
                            if (poll_nxt == CW'(pPOLL_MAX)) begin
                                state       <= RSP;
                                rsp_valid   <= 1'b1;
                                rsp_timeout <= 1'b1;
                            end else begin
                                state <= POLL_GAP;
                            end
                        end
                    end
                end
                POLL_GAP: begin
                    state   <= RD_A;
                    arvalid <= 1'b1;
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fir_cfg_master.md
FIR_CFG_MASTER -- requirements
Module: fir_cfg_master

Interface
REQ-001 Parameters SHALL be, one per line:
- pADDR_WIDTH, 12, AXI-Lite address width.
- pDATA_WIDTH, 32, AXI-Lite data width.
- pPOLL_MAX, 1024, maximum reads per poll command before timeout.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- axis_clk, in, 1, single clock; all logic on rising edge.
- axis_rst_n, in, 1, asynchronous active-low reset.
- cmd_valid, in, 1, command offered.
- cmd_ready, out, 1, command accepted when both cmd_valid and cmd_ready are high.
- cmd_op, in, 2, 00 write, 01 read, 10 poll, 11 reserved (treated as read).
- cmd_addr, in, pADDR_WIDTH, target register address.
- cmd_wdata, in, pDATA_WIDTH, write data (write op).
- cmd_mask, in, pDATA_WIDTH, poll completion mask (poll op).
- rsp_valid, out, 1, response available.
- rsp_ready, in, 1, response consumed when both rsp_valid and rsp_ready are high.
- rsp_data, out, pDATA_WIDTH, read data; 0 for writes.
- rsp_timeout, out, 1, poll ended without a mask match.
- awvalid, out, 1, AXI-Lite write address valid.
- awready, in, 1, AXI-Lite write address ready.
- awaddr, out, pADDR_WIDTH, AXI-Lite write address.
- wvalid, out, 1, AXI-Lite write data valid.
- wready, in, 1, AXI-Lite write data ready.
- wdata, out, pDATA_WIDTH, AXI-Lite write data.
- arvalid, out, 1, AXI-Lite read address valid.
- arready, in, 1, AXI-Lite read address ready.
- araddr, out, pADDR_WIDTH, AXI-Lite read address.
- rvalid, in, 1, AXI-Lite read data valid.
- rready, out, 1, AXI-Lite read data ready.
- rdata, in, pDATA_WIDTH, AXI-Lite read data.

REQ-003 The bus SHALL have no B channel; a write SHALL complete when both AW and W handshakes are done.

Function
REQ-004 States SHALL be IDLE, WR, RD_A, RD_D, POLL_GAP, RSP.
REQ-005 cmd_ready SHALL be 1 only in IDLE, with rsp_valid low.
REQ-006 On command accept, op/addr/wdata/mask SHALL be latched; later changes to cmd_* SHALL have no effect.

Write op:
REQ-007 IDLE->WR; awvalid and wvalid SHALL both rise in the cycle after accept.
REQ-008 Each of awvalid and wvalid SHALL drop in the cycle after its own handshake; either channel may complete first, or both in the same cycle.
REQ-009 When both handshakes are done, the FSM SHALL go to RSP with rsp_data=0 and rsp_timeout=0.

Read op:
REQ-010 IDLE->RD_A; arvalid=1 until arready. After the AR handshake: RD_D with rready=1 until rvalid.
REQ-011 On the R handshake, rsp_data SHALL latch rdata, then the FSM SHALL go to RSP.
REQ-012 arvalid and rready SHALL never be high in the same cycle.

Poll op:
REQ-013 Each poll iteration SHALL perform one read per REQ-010; rdata & mask != 0 -> RSP with rsp_data=rdata and rsp_timeout=0.
REQ-014 On no match, a 10-bit+ iteration counter SHALL increment. If the count reaches pPOLL_MAX -> RSP with rsp_timeout=1 and rsp_data=last rdata. Otherwise -> POLL_GAP for exactly 1 cycle, then RD_A.
REQ-015 mask=0 SHALL always time out after exactly pPOLL_MAX reads.

Response and bus-stable rules:
REQ-016 In RSP, rsp_valid=1 with rsp_data and rsp_timeout held stable until rsp_ready; the FSM SHALL then return to IDLE (cmd_ready high the next cycle).
REQ-017 awaddr, wdata and araddr SHALL be stable while their valid is high; all valid signals, once asserted, SHALL not drop before their handshake.
REQ-018 Minimum latency SHALL be: write with ready signals tied high, accept to rsp_valid = 2 cycles; read with arready=rvalid=1, 3 cycles.

Reset
REQ-019 axis_rst_n low SHALL asynchronously force state=IDLE and clear the iteration counter. Outputs SHALL reset to: awvalid=wvalid=arvalid=rready=0, rsp_valid=0, rsp_data=0, rsp_timeout=0, cmd_ready=0 while in reset; addresses and wdata = 0.
REQ-020 Reset mid-transaction SHALL abandon the transaction with no response issued; after release, cmd_ready=1 on the first clock edge.

Structure
REQ-021 A shared package fir_cfg_pkg SHALL hold the cmd_op encodings, the state enum, and the FIR register offsets (0x000 ap_ctrl, 0x010 data_length, 0x020 tap base).
REQ-022 Implementation SHALL be a single module, no sub-modules; iteration counter width = $clog2(pPOLL_MAX)+1.

Verification
REQ-023 Write 0x010 <- 0x00000258 with awready delayed 3 cycles and wready immediate: W handshake first; responder captures the value; rsp_valid=1, rsp_data=0.
REQ-024 Read 0x020 with arready=1 and rvalid delayed 5 cycles returning 0xFFFFFFF6: rsp_data=0xFFFFFFF6, timeout=0, and arvalid/rready never overlap.
REQ-025 Poll 0x000 with mask=0x2, responder returns 0x4 three times then 0x6: exactly 4 reads, POLL_GAP between reads, rsp_data=0x6, timeout=0.
REQ-026 Poll with mask=0x2 and the responder always returning 0 (pPOLL_MAX=8): exactly 8 reads, rsp_timeout=1.
REQ-027 Assert reset during RD_D, then issue a new write: all valid signals 0 immediately, no stale response, and the new write completes normally.
REQ-028 Hold rsp_ready=0 for 10 cycles with cmd_valid=1: cmd_ready stays 0, rsp_data stays stable, and the next command is accepted in the cycle after rsp_ready.
